regbank_write_arbiter: RTL and testbench
========================================

REGBANK_WRITE_ARBITER -- requirements
Module: regbank_write_arbiter

Interface
REQ-001 Parameters SHALL be (name, default, meaning): DATA_WIDTH, 64, write data width; BANK_ADDR_WIDTH, 64, width of the address driven into the register bank.
REQ-002 Port: clock  input  1  sole clock; all state changes on its rising edge.
REQ-003 Port: reset  input  1  asynchronous, active-high reset.
REQ-004 Port: req0_valid  input  1  requester 0 (execute writeback) has a write pending.
REQ-005 Port: req0_address  input  5  destination register index for requester 0.
REQ-006 Port: req0_data  input  DATA_WIDTH  write data for requester 0.
REQ-007 Port: req0_ready  output  1  requester 0 transfer accepted this cycle.
REQ-008 Port: req1_valid / req1_address / req1_data / req1_ready SHALL be identical to the req0 ports, for requester 1 (load writeback).
REQ-009 Port: write  output  1  register-bank write enable.
REQ-010 Port: write_address  output  BANK_ADDR_WIDTH  bank write address, 5-bit index zero-extended.
REQ-011 Port: write_data  output  DATA_WIDTH  bank write data.
REQ-012 Ports present only with WB_SCOREBOARD_EN: reserve_valid input 1; reserve_address input 5; query_address_1 input 5; query_address_2 input 5; query_busy_1 output 1; query_busy_2 output 1.

Function
REQ-013 A transfer SHALL occur on reqN when reqN_valid and reqN_ready are both high at a rising clock edge.
REQ-014 reqN_ready SHALL be combinational and high for at most one requester per cycle; ready SHALL never be high for a requester whose valid is low.
REQ-015 With only one valid requester, that requester SHALL be granted.
REQ-016 With both valid, the requester selected by a 1-bit priority pointer SHALL be granted; after any grant the pointer SHALL point to the non-granted requester (round-robin).
REQ-017 write, write_address and write_data SHALL be registered: a transfer at edge k drives write=1 with that address/data during cycle k+1 (latency 1).
REQ-018 Cycles following an edge with no transfer SHALL have write=0; write_address/write_data SHALL hold their last values.
REQ-019 Back-to-back transfers SHALL be sustained at one per cycle with no bubble.
REQ-020 A transfer with address 31 (zero register) SHALL be accepted (ready high) but SHALL produce write=0 in cycle k+1.
REQ-021 Requester address/data SHALL not be sampled except on a transfer edge.

Reset
REQ-022 While reset is high: write=0, write_address=0, write_data=0, pointer selects req0, all scoreboard bits clear, req0_ready=req1_ready=0.
REQ-023 Reset asserted mid-operation SHALL drop any registered write immediately (write=0 asynchronously); the dropped write SHALL never reach the bank.
REQ-024 First rising edge after reset deassertion SHALL be able to accept a transfer.

Configuration
REQ-025 Macro WB_SCOREBOARD_EN SHALL include a 32-entry pending-write scoreboard; without it, the REQ-012 ports and all scoreboard logic SHALL be absent and arbitration behaviour SHALL be unchanged.
REQ-026 With WB_SCOREBOARD_EN: reserve_valid at an edge SHALL set bit[reserve_address]; reserve of address 31 SHALL be ignored.
REQ-027 With WB_SCOREBOARD_EN: a transfer at an edge SHALL clear bit[address] at that same edge.
REQ-028 With WB_SCOREBOARD_EN: reserve and clear of the same address at one edge SHALL leave the bit set (new producer wins).
REQ-029 With WB_SCOREBOARD_EN: query_busy_n SHALL equal bit[query_address_n] combinationally; query of 31 SHALL return 0.

Verification
REQ-030 Reset, then req0 valid, address 5, data 0xAAAA for one cycle -> req0_ready=1 that cycle; next cycle write=1, write_address=5, write_data=0xAAAA; following cycle write=0.
REQ-031 Both valid continuously from reset (req0 addr 1, req1 addr 2) -> grants alternate req0, req1, req0, req1; write asserted every cycle with addresses 1, 2, 1, 2.
REQ-032 req1 valid, address 31, data 0xFFFF -> req1_ready=1; next cycle write=0.
REQ-033 Transfer accepted at edge k, reset pulsed during cycle k+1 -> write falls to 0 during reset; bank sees no write; pointer back to req0.
REQ-034 (WB_SCOREBOARD_EN) reserve address 7, query_address_1=7 -> query_busy_1=1 next cycle; req0 writes address 7 -> query_busy_1=0 after that transfer edge.
REQ-035 (WB_SCOREBOARD_EN) reserve 9 and req1 transfer to 9 at the same edge -> query_busy for 9 remains 1.

Source files
------------

// File: rtl/regbank_write_arbiter.sv
// ============================================================================
// regbank_write_arbiter
// ----------------------------------------------------------------------------
// Purpose:
//   Arbitrates two writeback requesters (req0 = execute, req1 = load) onto a
//   single register-bank write port. When both requesters are valid in the
//   same cycle, a 1-bit round-robin pointer chooses between them. The bank
//   write is registered, so its latency is one cycle. A write to register 31
//   (the zero register) is accepted but is never driven into the bank.
//
// Optional feature (macro WB_SCOREBOARD_EN):
//   Adds a 32-entry pending-write scoreboard. A reserve sets an entry. A
//   transfer to the same address clears that entry. Two combinational query
//   ports read the scoreboard back.
//
// Parameters:
//   DATA_WIDTH       write data width
//   BANK_ADDR_WIDTH  width of the bank address; the 5-bit index is
//                    zero-extended to this width (must be >= 5)
//
// Ports:
//   clock            sole clock, rising edge
//   reset            asynchronous, active-high reset
//   reqN_valid       requester N has a write pending
//   reqN_address     5-bit destination register index
//   reqN_data        write data
//   reqN_ready       combinational grant; a transfer happens when valid&ready
//   write            registered bank write enable
//   write_address    registered bank write address (zero-extended index)
//   write_data       registered bank write data
//   reserve_valid    (WB_SCOREBOARD_EN) mark reserve_address as pending
//   reserve_address  (WB_SCOREBOARD_EN) index to reserve
//   query_address_N  (WB_SCOREBOARD_EN) index to look up
//   query_busy_N     (WB_SCOREBOARD_EN) pending bit of query_address_N
// ============================================================================
module regbank_write_arbiter #(
   parameter int DATA_WIDTH      = 64,
   parameter int BANK_ADDR_WIDTH = 64
) (
   input  logic                       clock,
   input  logic                       reset,
   input  logic                       req0_valid,
   input  logic [4:0]                 req0_address,
   input  logic [DATA_WIDTH-1:0]      req0_data,
   output logic                       req0_ready,
   input  logic                       req1_valid,
   input  logic [4:0]                 req1_address,
   input  logic [DATA_WIDTH-1:0]      req1_data,
   output logic                       req1_ready,
   output logic                       write,
   output logic [BANK_ADDR_WIDTH-1:0] write_address,
   output logic [DATA_WIDTH-1:0]      write_data
`ifdef WB_SCOREBOARD_EN
   ,
   input  logic                       reserve_valid,
   input  logic [4:0]                 reserve_address,
   input  logic [4:0]                 query_address_1,
   input  logic [4:0]                 query_address_2,
   output logic                       query_busy_1,
   output logic                       query_busy_2
`endif
);

   localparam logic [4:0] ZERO_REG = 5'd31;

   // Round-robin pointer: 0 gives req0 priority, 1 gives req1 priority.
   logic                       ptr_r;
   logic                       write_r;
   logic [BANK_ADDR_WIDTH-1:0] write_address_r;
   logic [DATA_WIDTH-1:0]      write_data_r;

   logic                       grant0_s;
   logic                       grant1_s;
   logic                       xfer_s;
   logic                       do_write_s;
   logic [4:0]                 sel_address_s;
   logic [DATA_WIDTH-1:0]      sel_data_s;

   // Grant selection. Readies are held low while reset is asserted.
   always_comb begin
      grant0_s = 1'b0;
      grant1_s = 1'b0;
      if (reset) begin
         grant0_s = 1'b0;
         grant1_s = 1'b0;
      end else if (req0_valid && req1_valid) begin
         if (ptr_r) begin
            grant1_s = 1'b1;
         end else begin
            grant0_s = 1'b1;
         end
      end else if (req0_valid) begin
         grant0_s = 1'b1;
      end else if (req1_valid) begin
         grant1_s = 1'b1;
      end else begin
         grant0_s = 1'b0;
         grant1_s = 1'b0;
      end
   end

   // Mux the address and data of the granted requester.
   always_comb begin
      sel_address_s = req0_address;
      sel_data_s    = req0_data;
      if (grant1_s) begin
         sel_address_s = req1_address;
         sel_data_s    = req1_data;
      end else begin
         sel_address_s = req0_address;
         sel_data_s    = req0_data;
      end
   end

   assign xfer_s     = grant0_s | grant1_s;
   // A transfer to the zero register is consumed here and never reaches the bank.
   assign do_write_s = xfer_s && (sel_address_s != ZERO_REG);

   assign req0_ready = grant0_s;
   assign req1_ready = grant1_s;

   // Bank write pipeline stage and round-robin pointer update.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         write_r         <= 1'b0;
         write_address_r <= {BANK_ADDR_WIDTH{1'b0}};
         write_data_r    <= {DATA_WIDTH{1'b0}};
         ptr_r           <= 1'b0;
      end else begin
         write_r <= do_write_s;
         // Address/data only change on a real bank write so they hold otherwise.
         if (do_write_s) begin
            write_address_r <= {{(BANK_ADDR_WIDTH-5){1'b0}}, sel_address_s};
            write_data_r    <= sel_data_s;
         end
         // After any grant, the pointer moves to the requester that was not granted.
         if (xfer_s) begin
            ptr_r <= grant0_s;
         end
      end
   end

   assign write         = write_r;
   assign write_address = write_address_r;
   assign write_data    = write_data_r;

`ifdef WB_SCOREBOARD_EN
   logic [31:0] sb_r;
   logic [31:0] sb_set_s;
   logic [31:0] sb_clr_s;
   logic [31:0] sb_next_s;

   // Scoreboard next state. A set is applied after a clear, so a new producer wins.
   always_comb begin
      sb_set_s = 32'd0;
      sb_clr_s = 32'd0;
      if (reserve_valid && (reserve_address != ZERO_REG)) begin
         sb_set_s = 32'd1 << reserve_address;
      end else begin
         sb_set_s = 32'd0;
      end
      if (xfer_s) begin
         sb_clr_s = 32'd1 << sel_address_s;
      end else begin
         sb_clr_s = 32'd0;
      end
      sb_next_s = (sb_r & ~sb_clr_s) | sb_set_s;
   end

   // Scoreboard state register.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         sb_r <= 32'd0;
      end else begin
         sb_r <= sb_next_s;
      end
   end

   assign query_busy_1 = (query_address_1 == ZERO_REG) ? 1'b0 : sb_r[query_address_1];
   assign query_busy_2 = (query_address_2 == ZERO_REG) ? 1'b0 : sb_r[query_address_2];
`endif

endmodule

// File: tb/tb_regbank_write_arbiter.sv
module tb_regbank_write_arbiter;

   localparam int DW = 64;
   localparam int AW = 64;

   logic          clock = 1'b0;
   logic          reset;
   logic          req0_valid, req1_valid;
   logic [4:0]    req0_address, req1_address;
   logic [DW-1:0] req0_data, req1_data;
   logic          req0_ready, req1_ready;
   logic          write;
   logic [AW-1:0] write_address;
   logic [DW-1:0] write_data;
`ifdef WB_SCOREBOARD_EN
   logic          reserve_valid;
   logic [4:0]    reserve_address;
   logic [4:0]    query_address_1, query_address_2;
   logic          query_busy_1, query_busy_2;
`endif

   int errors = 0;
   int checks = 0;

   // Reference model state: which requester wins a tie, and the expected bank port.
   int            prio;
   logic          exp_write;
   logic [AW-1:0] exp_addr;
   logic [DW-1:0] exp_data;

   regbank_write_arbiter #(.DATA_WIDTH(DW), .BANK_ADDR_WIDTH(AW)) dut (
      .clock         (clock),
      .reset         (reset),
      .req0_valid    (req0_valid),
      .req0_address  (req0_address),
      .req0_data     (req0_data),
      .req0_ready    (req0_ready),
      .req1_valid    (req1_valid),
      .req1_address  (req1_address),
      .req1_data     (req1_data),
      .req1_ready    (req1_ready),
      .write         (write),
      .write_address (write_address),
      .write_data    (write_data)
`ifdef WB_SCOREBOARD_EN
      ,
      .reserve_valid   (reserve_valid),
      .reserve_address (reserve_address),
      .query_address_1 (query_address_1),
      .query_address_2 (query_address_2),
      .query_busy_1    (query_busy_1),
      .query_busy_2    (query_busy_2)
`endif
   );

   always #5 clock = ~clock;

   initial begin
      #2000000;
      $display("FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      prio      = 0;
      exp_write = 1'b0;
      exp_addr  = '0;
      exp_data  = '0;
   endtask

   // Runs one clock cycle. It is entered and left on a falling edge.
   task automatic cycle(input logic v0, input logic [4:0] a0, input logic [DW-1:0] d0,
                        input logic v1, input logic [4:0] a1, input logic [DW-1:0] d1);
      int g;
      logic [4:0]    ga;
      logic [DW-1:0] gd;
      req0_valid = v0; req0_address = a0; req0_data = d0;
      req1_valid = v1; req1_address = a1; req1_data = d1;
      #1;
      g = -1;
      if (v0 && v1)  g = prio;
      else if (v0)   g = 0;
      else if (v1)   g = 1;
      chk("req0_ready", req0_ready, g == 0);
      chk("req1_ready", req1_ready, g == 1);
      @(posedge clock);
      if (g >= 0) begin
         prio = 1 - g;
         ga = (g == 0) ? a0 : a1;
         gd = (g == 0) ? d0 : d1;
         exp_write = (ga != 5'd31);
         if (exp_write) begin
            exp_addr = {59'd0, ga};
            exp_data = gd;
         end
      end else begin
         exp_write = 1'b0;
      end
      #1;
      chk("write", write, exp_write);
      chk("write_address", write_address, exp_addr);
      chk("write_data", write_data, exp_data);
      @(negedge clock);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      req0_valid = 1'b1;
      req1_valid = 1'b1;
      #1;
      chk("rst_write", write, 1'b0);
      chk("rst_write_address", write_address, 64'd0);
      chk("rst_write_data", write_data, 64'd0);
      chk("rst_req0_ready", req0_ready, 1'b0);
      chk("rst_req1_ready", req1_ready, 1'b0);
      @(negedge clock);
      @(negedge clock);
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      reset = 1'b0;
      model_reset();
   endtask

   initial begin
      logic [DW-1:0] rd0, rd1;
      logic [4:0]    ra0, ra1;
      model_reset();
      reset = 1'b1;
      req0_valid = 1'b0; req1_valid = 1'b0;
      req0_address = 5'd0; req1_address = 5'd0;
      req0_data = '0; req1_data = '0;
`ifdef WB_SCOREBOARD_EN
      reserve_valid = 1'b0; reserve_address = 5'd0;
      query_address_1 = 5'd0; query_address_2 = 5'd0;
`endif
      #2;
      do_reset();

      // Single transfer from req0, then an idle cycle.
      cycle(1'b1, 5'd5, 64'hAAAA, 1'b0, 5'd0, 64'd0);
      chk("d1_addr5", write_address, 64'd5);
      chk("d1_dataAAAA", write_data, 64'hAAAA);
      cycle(1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0);

      // Both requesters valid from reset: grants alternate 0,1,0,1.
      do_reset();
      for (int i = 0; i < 4; i++) begin
         cycle(1'b1, 5'd1, 64'h1111, 1'b1, 5'd2, 64'h2222);
         chk("rr_address", write_address, (i % 2 == 0) ? 64'd1 : 64'd2);
      end

      // A write to the zero register is accepted but not forwarded; the last values are held.
      cycle(1'b0, 5'd0, 64'd0, 1'b1, 5'd31, 64'hFFFF);
      chk("zero_reg_write", write, 1'b0);
      chk("zero_reg_hold_addr", write_address, 64'd2);

      // Reset in the cycle after a transfer drops the pending write.
      cycle(1'b1, 5'd3, 64'h3333, 1'b0, 5'd0, 64'd0);
      chk("pre_rst_write", write, 1'b1);
      reset = 1'b1;
      req0_valid = 1'b0;
      #1;
      chk("async_rst_write", write, 1'b0);
      chk("async_rst_addr", write_address, 64'd0);
      @(negedge clock);
      reset = 1'b0;
      model_reset();
      // The pointer is back on req0, and the first edge after reset accepts a transfer.
      cycle(1'b1, 5'd4, 64'h4444, 1'b1, 5'd6, 64'h6666);
      chk("post_rst_addr", write_address, 64'd4);

      // Randomized traffic checked against the model.
      for (int i = 0; i < 300; i++) begin
         ra0 = ($urandom_range(0, 7) == 0) ? 5'd31 : 5'($urandom_range(0, 31));
         ra1 = ($urandom_range(0, 7) == 0) ? 5'd31 : 5'($urandom_range(0, 31));
         rd0 = {$urandom, $urandom};
         rd1 = {$urandom, $urandom};
         cycle(1'($urandom_range(0, 1)), ra0, rd0, 1'($urandom_range(0, 1)), ra1, rd1);
      end

`ifdef WB_SCOREBOARD_EN
      // Scoreboard: a reserve sets the bit and a transfer clears it.
      reserve_valid = 1'b1; reserve_address = 5'd7; query_address_1 = 5'd7;
      cycle(1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0);
      reserve_valid = 1'b0;
      #1;
      chk("sb_busy7", query_busy_1, 1'b1);
      cycle(1'b1, 5'd7, 64'h7777, 1'b0, 5'd0, 64'd0);
      chk("sb_clear7", query_busy_1, 1'b0);
      // A reserve and a clear of the same address at one edge leave the bit set.
      reserve_valid = 1'b1; reserve_address = 5'd9; query_address_2 = 5'd9;
      cycle(1'b0, 5'd0, 64'd0, 1'b1, 5'd9, 64'h9999);
      reserve_valid = 1'b0;
      #1;
      chk("sb_same_edge9", query_busy_2, 1'b1);
      // A reserve of the zero register is ignored.
      reserve_valid = 1'b1; reserve_address = 5'd31; query_address_1 = 5'd31;
      cycle(1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0);
      reserve_valid = 1'b0;
      #1;
      chk("sb_zero31", query_busy_1, 1'b0);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
